// File: rtl/vx_dispatch_batcher.sv
// vx_dispatch_batcher: serialises one full-warp dispatch packet into NUM_LANES-wide beats.
// Define VX_BATCH_SKIP_EMPTY_EN to skip batches whose tmask slice is all zero.
module vx_dispatch_batcher #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_LANES   = 2,
  parameter int XLEN        = 32,
  parameter int HDR_W       = 64,
  localparam int NUM_PACKETS = NUM_THREADS / NUM_LANES,
  localparam int PID_W       = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [HDR_W-1:0]           in_hdr,
  input  logic [NUM_THREADS-1:0]     in_tmask,
  input  logic [NUM_THREADS*XLEN-1:0] in_rs1_data,
  input  logic [NUM_THREADS*XLEN-1:0] in_rs2_data,
  input  logic [NUM_THREADS*XLEN-1:0] in_rs3_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [HDR_W-1:0]           out_hdr,
  output logic [NUM_LANES-1:0]       out_tmask,
  output logic [NUM_LANES*XLEN-1:0]  out_rs1_data,
  output logic [NUM_LANES*XLEN-1:0]  out_rs2_data,
  output logic [NUM_LANES*XLEN-1:0]  out_rs3_data,
  output logic [PID_W-1:0]           out_pid,
  output logic                       out_sop,
  output logic                       out_eop
);
  if ((NUM_THREADS % NUM_LANES) != 0) begin : g_bad_cfg
    $error("NUM_LANES must divide NUM_THREADS");
  end
  logic                        busy_q, busy_d;
  logic [PID_W-1:0]            pid_q, pid_d;
  logic [HDR_W-1:0]            hdr_q, hdr_d;
  logic [NUM_THREADS-1:0]      tmask_q, tmask_d;
  logic [NUM_THREADS*XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d;
  logic [NUM_PACKETS-1:0]      nz_in, nz_q;
  logic [PID_W-1:0]            first_in, first_q, last_q, next_q;
  logic                        out_fire, in_fire;
  // Batches eligible for emission; without skipping every batch qualifies.
  always_comb begin
    for (int p = 0; p < NUM_PACKETS; p++) begin
`ifdef VX_BATCH_SKIP_EMPTY_EN
      nz_in[p] = |in_tmask[p*NUM_LANES +: NUM_LANES];
      nz_q[p]  = |tmask_q[p*NUM_LANES +: NUM_LANES];
`else
      nz_in[p] = 1'b1;
      nz_q[p]  = 1'b1;
`endif
    end
  end
  // Priority encoders; an empty mask falls back to batch 0 so one beat still leaves.
  always_comb begin
    first_in = '0;
    first_q  = '0;
    last_q   = '0;
    next_q   = pid_q;
    for (int p = NUM_PACKETS - 1; p >= 0; p--) begin
      first_in = nz_in[p] ? PID_W'(p) : first_in;
      first_q  = nz_q[p] ? PID_W'(p) : first_q;
      next_q   = (nz_q[p] && p > int'(pid_q)) ? PID_W'(p) : next_q;
    end
    for (int p = 0; p < NUM_PACKETS; p++)
      last_q = nz_q[p] ? PID_W'(p) : last_q;
  end
  assign out_valid    = busy_q;
  assign out_pid      = pid_q;
  assign out_sop      = busy_q && (pid_q == first_q);
  assign out_eop      = busy_q && (pid_q == last_q);
  assign out_hdr      = hdr_q;
  assign out_tmask    = tmask_q[pid_q*NUM_LANES +: NUM_LANES];
  assign out_rs1_data = rs1_q[pid_q*NUM_LANES*XLEN +: NUM_LANES*XLEN];
  assign out_rs2_data = rs2_q[pid_q*NUM_LANES*XLEN +: NUM_LANES*XLEN];
  assign out_rs3_data = rs3_q[pid_q*NUM_LANES*XLEN +: NUM_LANES*XLEN];
  assign out_fire     = busy_q && out_ready;
  assign in_ready     = !busy_q || (out_fire && out_eop);
  assign in_fire      = in_valid && in_ready;
  always_comb begin
    busy_d  = in_fire || (busy_q && !(out_fire && out_eop));
    pid_d   = in_fire ? first_in : (out_fire && !out_eop) ? next_q : pid_q;
    hdr_d   = in_fire ? in_hdr : hdr_q;
    tmask_d = in_fire ? in_tmask : tmask_q;
    rs1_d   = in_fire ? in_rs1_data : rs1_q;
    rs2_d   = in_fire ? in_rs2_data : rs2_q;
    rs3_d   = in_fire ? in_rs3_data : rs3_q;
  end
  always_ff @(posedge clk) begin
    busy_q  <= reset ? 1'b0 : busy_d;
    pid_q   <= reset ? '0 : pid_d;
    hdr_q   <= hdr_d;
    tmask_q <= tmask_d;
    rs1_q   <= rs1_d;
    rs2_q   <= rs2_d;
    rs3_q   <= rs3_d;
  end
endmodule

// File: tb/tb_vx_dispatch_batcher.sv
// tb_vx_dispatch_batcher: directed bench with a beat-queue model of vx_dispatch_batcher.
module tb_vx_dispatch_batcher;
  localparam int NT = 4, NL = 2, XL = 32, HW = 64;
  localparam int NP = NT / NL;
  localparam int PW = (NP > 1) ? $clog2(NP) : 1;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_sop, out_eop;
  logic [HW-1:0] in_hdr = '0, out_hdr;
  logic [NT-1:0] in_tmask = '0;
  logic [NL-1:0] out_tmask;
  logic [NT*XL-1:0] in_rs1 = '0, in_rs2 = '0, in_rs3 = '0;
  logic [NL*XL-1:0] out_rs1, out_rs2, out_rs3;
  logic [PW-1:0] out_pid;
  typedef struct packed {
    logic [HW-1:0]    hdr;
    logic [NL-1:0]    tm;
    logic [NL*XL-1:0] r1, r2, r3;
    logic [PW-1:0]    pid;
    logic             sop, eop;
  } beat_t;
  beat_t q[$];
  int total = 0, bad = 0;
  bit started = 0, in_fire_m = 0, rnd_ready = 0;
  logic [319:0] snap;
  vx_dispatch_batcher #(.NUM_THREADS(NT), .NUM_LANES(NL), .XLEN(XL), .HDR_W(HW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_hdr(in_hdr),
    .in_tmask(in_tmask), .in_rs1_data(in_rs1), .in_rs2_data(in_rs2), .in_rs3_data(in_rs3),
    .out_valid(out_valid), .out_ready(out_ready), .out_hdr(out_hdr), .out_tmask(out_tmask),
    .out_rs1_data(out_rs1), .out_rs2_data(out_rs2), .out_rs3_data(out_rs3),
    .out_pid(out_pid), .out_sop(out_sop), .out_eop(out_eop)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  function automatic bit exp_in_ready();
    return (q.size() == 0) || (out_ready && q[0].eop);
  endfunction
  // Expand an accepted packet into the list of beats it must produce.
  task automatic push_pkt();
    int sel[$];
    beat_t b;
    for (int p = 0; p < NP; p++) begin
`ifdef VX_BATCH_SKIP_EMPTY_EN
      if (in_tmask[p*NL +: NL] != '0) sel.push_back(p);
`else
      sel.push_back(p);
`endif
    end
    if (sel.size() == 0) sel.push_back(0);
    foreach (sel[k]) begin
      b.hdr = in_hdr;
      b.tm  = in_tmask[sel[k]*NL +: NL];
      b.r1  = in_rs1[sel[k]*NL*XL +: NL*XL];
      b.r2  = in_rs2[sel[k]*NL*XL +: NL*XL];
      b.r3  = in_rs3[sel[k]*NL*XL +: NL*XL];
      b.pid = PW'(sel[k]);
      b.sop = (k == 0);
      b.eop = (k == sel.size() - 1);
      q.push_back(b);
    end
  endtask
  always @(posedge clk) begin
    bit rdy;
    started = 1;
    in_fire_m = 0;
    if (reset) q.delete();
    else begin
      rdy = exp_in_ready();
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (in_valid && rdy) begin
        in_fire_m = 1;
        push_pkt();
      end
    end
  end
  always @(negedge clk) if (started) begin
    beat_t a;
    a = {out_hdr, out_tmask, out_rs1, out_rs2, out_rs3, out_pid, out_sop, out_eop};
    chk("out_valid", 320'(out_valid), 320'(q.size() > 0));
    chk("in_ready", 320'(in_ready), 320'(exp_in_ready()));
    if (q.size() > 0) chk("beat", a, q[0]);
  end
  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask
  task automatic set_pkt(input logic [HW-1:0] h, input logic [NT-1:0] tm, input logic [31:0] base);
    in_hdr = h;
    in_tmask = tm;
    for (int t = 0; t < NT; t++) begin
      in_rs1[t*XL +: XL] = base + 32'(t);
      in_rs2[t*XL +: XL] = base + 32'h100 + 32'(t);
      in_rs3[t*XL +: XL] = base + 32'h200 + 32'(t);
    end
    in_valid = 1'b1;
  endtask
  task automatic send(input logic [HW-1:0] h, input logic [NT-1:0] tm, input logic [31:0] base);
    int n = 0;
    set_pkt(h, tm, base);
    do begin
      step();
      n++;
    end while (!in_fire_m && n < 50);
    chk("in_fire", 320'(in_fire_m), 320'(1));
    in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 60) begin
      step();
      n++;
    end
    chk("drain", 320'(q.size()), 320'(0));
    rnd_ready = 0;
    out_ready = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: no finish by 200000");
    $fatal(1);
  end
  initial begin
    logic [3:0] tms [5] = '{4'b0011, 4'b0110, 4'b1000, 4'b0101, 4'b0001};
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", 320'(out_valid), 320'(0));
    chk("rst_sop", 320'(out_sop), 320'(0));
    chk("rst_eop", 320'(out_eop), 320'(0));
    chk("rst_pid", 320'(out_pid), 320'(0));
    chk("rst_in_ready", 320'(in_ready), 320'(1));
    // T1: single full packet
    step();
    send(64'hA, 4'b1111, 32'h1000);
    @(negedge clk);
    chk("t1_b0", {out_pid, out_sop, out_eop, out_tmask, out_rs1}, {1'b0, 1'b1, 1'b0, 2'b11, 32'h1001, 32'h1000});
    @(negedge clk);
    chk("t1_b1", {out_pid, out_sop, out_eop, out_rs1}, {1'b1, 1'b0, 1'b1, 32'h1003, 32'h1002});
    step();
    @(negedge clk);
    chk("t1_idle", 320'(out_valid), 320'(0));
    // T2: back-to-back packets without a bubble
    step();
    set_pkt(64'hB, 4'b1111, 32'h2000);
    step();
    chk("t2_b_fire", 320'(in_fire_m), 320'(1));
    set_pkt(64'hC, 4'b1111, 32'h3000);
    @(negedge clk);
    chk("t2_b0_in_ready", 320'(in_ready), 320'(0));
    step();
    chk("t2_c_wait", 320'(in_fire_m), 320'(0));
    @(negedge clk);
    chk("t2_b1_eop_rdy", {out_eop, in_ready}, 2'b11);
    step();
    chk("t2_c_fire", 320'(in_fire_m), 320'(1));
    in_valid = 1'b0;
    @(negedge clk);
    chk("t2_c0", {out_valid, out_sop, out_hdr}, {1'b1, 1'b1, 64'hC});
    step();
    step();
    // T3: stall on beat 0
    out_ready = 1'b0;
    send(64'hD, 4'b1111, 32'h4000);
    @(negedge clk);
    snap = {out_hdr, out_tmask, out_rs1, out_rs2, out_rs3, out_pid, out_sop, out_eop};
    chk("t3_stall", {out_pid, in_ready}, 2'b00);
    repeat (2) begin
      step();
      @(negedge clk);
      chk("t3_hold", {out_hdr, out_tmask, out_rs1, out_rs2, out_rs3, out_pid, out_sop, out_eop}, snap);
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_b0", {out_valid, out_pid}, 2'b10);
    step();
    @(negedge clk);
    chk("t3_b1", {out_pid, out_eop}, 2'b11);
    step();
    // T4: upper batch only
    send(64'hE, 4'b1100, 32'h5000);
    @(negedge clk);
`ifdef VX_BATCH_SKIP_EMPTY_EN
    chk("t4_b", {out_pid, out_sop, out_eop, out_tmask}, 5'b1_1_1_11);
    step();
    @(negedge clk);
    chk("t4_done", 320'(out_valid), 320'(0));
`else
    chk("t4_b0", {out_pid, out_sop, out_eop, out_tmask}, 5'b0_1_0_00);
    step();
    @(negedge clk);
    chk("t4_b1", {out_pid, out_sop, out_eop, out_tmask}, 5'b1_0_1_11);
`endif
    step();
    // T5: all-zero mask
    send(64'hF, 4'b0000, 32'h6000);
    @(negedge clk);
`ifdef VX_BATCH_SKIP_EMPTY_EN
    chk("t5_b", {out_pid, out_sop, out_eop, out_tmask}, 5'b0_1_1_00);
    step();
    @(negedge clk);
    chk("t5_done", 320'(out_valid), 320'(0));
`else
    chk("t5_b0", {out_pid, out_sop, out_eop, out_tmask}, 5'b0_1_0_00);
    step();
    @(negedge clk);
    chk("t5_b1", {out_pid, out_sop, out_eop, out_tmask}, 5'b1_0_1_00);
`endif
    step();
    // T6: reset mid-packet
    send(64'h10, 4'b1111, 32'h7000);
    @(negedge clk);
    chk("t6_b0", {out_pid, out_sop}, 2'b01);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_flushed", {out_valid, in_ready}, 2'b01);
    step();
    send(64'h11, 4'b1111, 32'h8000);
    @(negedge clk);
    chk("t6_restart", {out_pid, out_sop, out_hdr}, {1'b0, 1'b1, 64'h11});
    drain();
    // Mixed masks under random backpressure
    rnd_ready = 1;
    foreach (tms[i]) send(64'h100 + 64'(i), tms[i], 32'h9000 + 32'(i) * 32'h1000);
    drain();
    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
